instr_fetch: RTL and testbench

Instruction fetch and issue unit: the producer side of the control decoder's 5-bit instruction input. It sequences the program counter and reads a synchronous instruction ROM. It presents each instruction word to decode/execute with a valid/ready handshake, then resolves taken branches through a branch-target lookup table. It sits between the instruction memory and the control decoder and owns program start, halt and done.

---
 rtl/instr_fetch_pkg.sv | 31 +++
 rtl/instr_fetch_if.sv | 31 +++
 rtl/instr_fetch_branch_lut.sv | 14 +
 rtl/instr_fetch.sv | 107 ++++++++++
 tb/tb_instr_fetch.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch/issue unit: widths, FSM state type,
// HALT encoding, opcodes and the fixed branch-target table.
package fetch_pkg;

  localparam int DEF_IW   = 9;
  localparam int DEF_PCW  = 10;
  localparam int DEF_LUTW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } fetch_state_t;

  localparam logic [DEF_IW-1:0] HALT_WORD = 9'h1FF;

  // Decoder opcode lives in instr[8:6]
  localparam logic [2:0] OP_ALU = 3'b000;
  localparam logic [2:0] OP_BEQ = 3'b001;
  localparam logic [2:0] OP_LD  = 3'b010;
  localparam logic [2:0] OP_ST  = 3'b011;

  localparam logic [DEF_PCW-1:0] BR_TARGETS [2**DEF_LUTW] = '{
    10'd0,   10'd16,  10'd32,  10'd48,
    10'd10,  10'd64,  10'd80,  10'd96,
    10'd128, 10'd160, 10'd200, 10'd256,
    10'd300, 10'd400, 10'd512, 10'd1000
  };

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory and issue-side handshake bundle of instr_fetch.
// master = fetch unit, slave = memory/decoder side.
interface instr_fetch_if
  import fetch_pkg::*;
#(
  parameter int IW  = DEF_IW,
  parameter int PCW = DEF_PCW
);

  logic           imem_en_o;
  logic [PCW-1:0] imem_addr_o;
  logic [IW-1:0]  imem_data_i;
  logic [IW-1:0]  instr_o;
  logic [4:0]     ctrl_instr_o;
  logic           instr_valid_o;
  logic           instr_ready_i;
  logic           branch_i;
  logic           zero_i;
  logic [PCW-1:0] pc_o;

  modport master (
    output imem_en_o, imem_addr_o, instr_o, ctrl_instr_o, instr_valid_o, pc_o,
    input  imem_data_i, instr_ready_i, branch_i, zero_i
  );

  modport slave (
    input  imem_en_o, imem_addr_o, instr_o, ctrl_instr_o, instr_valid_o, pc_o,
    output imem_data_i, instr_ready_i, branch_i, zero_i
  );

endinterface

// File: rtl/instr_fetch_branch_lut.sv
// Combinational branch-target lookup: LUT index from the instruction's low bits
// to a PC value taken from fetch_pkg::BR_TARGETS.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PCW = DEF_PCW
) (
  input  logic [DEF_LUTW-1:0] i_idx,
  output logic [PCW-1:0]      o_target
);

  assign o_target = BR_TARGETS[i_idx][PCW-1:0];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue FSM: sequences the PC, reads the synchronous ROM and issues
// words over valid/ready. Optional $write trace when FETCH_TRACE_EN is defined.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int IW  = DEF_IW,
  parameter int PCW = DEF_PCW
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          start_i,
  output logic          done_o,
  output logic          err_o,
  instr_fetch_if.master bus
);

  localparam logic [PCW-1:0] PC_MAX = '1;

  fetch_state_t   r_state, w_state_nxt;
  logic [PCW-1:0] r_pc, w_pc_nxt, w_target;
  logic [IW-1:0]  r_instr, w_instr;
  logic           r_cap, r_err, w_err_nxt;
  logic           w_accept, w_halt, w_taken, w_last;

  // ROM data is only valid in the first ISSUE cycle; pass it through, then hold the copy
  assign w_instr  = r_cap ? bus.imem_data_i : r_instr;
  assign w_accept = (r_state == S_ISSUE) && bus.instr_ready_i;
  assign w_halt   = (w_instr == HALT_WORD);
  assign w_taken  = bus.branch_i && bus.zero_i;
  assign w_last   = (r_pc == PC_MAX);

  branch_lut #(.PCW(PCW)) u_branch_lut (
    .i_idx    (w_instr[DEF_LUTW-1:0]),
    .o_target (w_target)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_instr <= '0;
      r_cap   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_err   <= w_err_nxt;
      r_cap   <= (r_state == S_FETCH);
      if (r_cap) r_instr <= bus.imem_data_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = '0;
          w_err_nxt   = 1'b0;
        end
      end
      S_FETCH: w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (w_accept) begin
          if (w_halt) begin
            w_state_nxt = S_DONE;
          end else if (w_taken) begin
            w_pc_nxt    = w_target;
            w_state_nxt = S_FETCH;
          end else if (w_last) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_pc_nxt    = r_pc + 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.imem_en_o     = (r_state == S_FETCH);
  assign bus.imem_addr_o   = r_pc;
  assign bus.instr_o       = w_instr;
  assign bus.ctrl_instr_o  = w_instr[IW-1 -: 5];
  assign bus.instr_valid_o = (r_state == S_ISSUE);
  assign bus.pc_o          = r_pc;
  assign done_o            = (r_state == S_DONE);
  assign err_o             = r_err;

`ifdef FETCH_TRACE_EN
  always @(posedge Clk) begin
    if (Reset_n && w_accept)
      $write("fetch: pc=%0d instr=%03h op=%0d %s\n", r_pc, w_instr, w_instr[IW-1 -: 3],
             (w_taken && !w_halt) ? "taken" : "not-taken");
    if (Reset_n && (r_state != S_DONE) && (w_state_nxt == S_DONE))
      $write("fetch: done %s\n", w_err_nxt ? "err (pc overflow)" : "halt");
  end
`else
  // trace disabled: no simulation output
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized programs
// checked against a small instruction-level interpreter of the fetch rules.
module tb_instr_fetch;

  logic clk;
  logic rst_n;
  logic start_m, done_m, err_m;
  logic start_o, done_o_ov, err_o_ov;
  int   total;
  int   bad;

  logic [8:0] rom    [1024];
  logic [8:0] rom_ov [8];
  logic [9:0] tb_targets [16];

  instr_fetch_if #(.IW(9), .PCW(10)) bus_m ();
  instr_fetch_if #(.IW(9), .PCW(3))  bus_o ();

  instr_fetch #(.IW(9), .PCW(10)) dut (
    .Clk(clk), .Reset_n(rst_n), .start_i(start_m), .done_o(done_m), .err_o(err_m), .bus(bus_m)
  );

  instr_fetch #(.IW(9), .PCW(3)) dut_ov (
    .Clk(clk), .Reset_n(rst_n), .start_i(start_o), .done_o(done_o_ov), .err_o(err_o_ov), .bus(bus_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus_m.imem_en_o) bus_m.imem_data_i <= rom[bus_m.imem_addr_o];
  always @(posedge clk) if (bus_o.imem_en_o) bus_o.imem_data_i <= rom_ov[bus_o.imem_addr_o];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_m = 0; start_o = 0;
    bus_m.instr_ready_i = 0; bus_m.branch_i = 0; bus_m.zero_i = 0;
    bus_o.instr_ready_i = 0; bus_o.branch_i = 0; bus_o.zero_i = 0;
    tick(); tick();
    total++;
    if ({bus_m.imem_en_o, bus_m.imem_addr_o, bus_m.instr_o, bus_m.ctrl_instr_o,
         bus_m.instr_valid_o, bus_m.pc_o, done_m, err_m} !== '0) begin
      bad++;
      $display("FAIL reset_main en=%b addr=%0d instr=%h valid=%b pc=%0d done=%b err=%b want all 0",
               bus_m.imem_en_o, bus_m.imem_addr_o, bus_m.instr_o, bus_m.instr_valid_o,
               bus_m.pc_o, done_m, err_m);
    end
    total++;
    if ({bus_o.imem_en_o, bus_o.imem_addr_o, bus_o.instr_o, bus_o.instr_valid_o,
         bus_o.pc_o, done_o_ov, err_o_ov} !== '0) begin
      bad++;
      $display("FAIL reset_ov en=%b addr=%0d valid=%b done=%b err=%b want all 0",
               bus_o.imem_en_o, bus_o.imem_addr_o, bus_o.instr_valid_o, done_o_ov, err_o_ov);
    end
    rst_n = 1'b1;
    tick(); tick();
    total++;
    if ({bus_m.imem_en_o, bus_m.instr_valid_o, bus_m.pc_o, done_m, err_m} !== '0) begin
      bad++;
      $display("FAIL idle_outs en=%b valid=%b pc=%0d done=%b err=%b want all 0",
               bus_m.imem_en_o, bus_m.instr_valid_o, bus_m.pc_o, done_m, err_m);
    end
  endtask

  task automatic test_straight();
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    rom[0] = 9'h000; rom[1] = 9'h020; rom[2] = 9'h040; rom[3] = 9'h1FF;
    bus_m.instr_ready_i = 1; bus_m.branch_i = 0; bus_m.zero_i = 0;
    start_m = 1; tick(); start_m = 0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (bus_m.imem_en_o !== 1'b1 || bus_m.imem_addr_o !== 10'(k) || bus_m.instr_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL straight_fetch en=%b addr=%0d valid=%b want en=1 addr=%0d valid=0",
                 bus_m.imem_en_o, bus_m.imem_addr_o, bus_m.instr_valid_o, k);
      end
      tick();
      total++;
      if (bus_m.instr_valid_o !== 1'b1 || bus_m.pc_o !== 10'(k) || bus_m.instr_o !== rom[k] ||
          bus_m.ctrl_instr_o !== rom[k][8:4]) begin
        bad++;
        $display("FAIL straight_issue valid=%b pc=%0d instr=%h ctrl=%h want valid=1 pc=%0d instr=%h ctrl=%h",
                 bus_m.instr_valid_o, bus_m.pc_o, bus_m.instr_o, bus_m.ctrl_instr_o, k, rom[k], rom[k][8:4]);
      end
      tick();
    end
    total++;
    if (done_m !== 1'b1 || err_m !== 1'b0 || bus_m.instr_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL straight_done done=%b err=%b valid=%b want done=1 err=0 valid=0",
               done_m, err_m, bus_m.instr_valid_o);
    end
  endtask

  task automatic test_restart();
    bit seen;
    start_m = 1; tick(); start_m = 0;
    total++;
    if (done_m !== 1'b0 || err_m !== 1'b0 || bus_m.imem_en_o !== 1'b1 || bus_m.imem_addr_o !== 10'd0) begin
      bad++;
      $display("FAIL restart_clear done=%b err=%b en=%b addr=%0d want done=0 err=0 en=1 addr=0",
               done_m, err_m, bus_m.imem_en_o, bus_m.imem_addr_o);
    end
    tick();
    total++;
    if (bus_m.instr_valid_o !== 1'b1 || bus_m.pc_o !== 10'd0 || bus_m.instr_o !== rom[0]) begin
      bad++;
      $display("FAIL restart_issue valid=%b pc=%0d instr=%h want valid=1 pc=0 instr=%h",
               bus_m.instr_valid_o, bus_m.pc_o, bus_m.instr_o, rom[0]);
    end
    bus_m.instr_ready_i = 0; start_m = 1; tick(); start_m = 0;
    total++;
    if (bus_m.instr_valid_o !== 1'b1 || bus_m.pc_o !== 10'd0 || bus_m.imem_en_o !== 1'b0 || done_m !== 1'b0) begin
      bad++;
      $display("FAIL start_in_issue valid=%b pc=%0d en=%b done=%b want valid=1 pc=0 en=0 done=0",
               bus_m.instr_valid_o, bus_m.pc_o, bus_m.imem_en_o, done_m);
    end
    bus_m.instr_ready_i = 1; tick();
    total++;
    if (bus_m.imem_en_o !== 1'b1 || bus_m.imem_addr_o !== 10'd1) begin
      bad++;
      $display("FAIL restart_next en=%b addr=%0d want en=1 addr=1", bus_m.imem_en_o, bus_m.imem_addr_o);
    end
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = done_m;
    end
    total++;
    if (!seen || err_m !== 1'b0) begin
      bad++;
      $display("FAIL restart_done done_seen=%b err=%b want done_seen=1 err=0", seen, err_m);
    end
  endtask

  task automatic test_branch(input bit zero_val);
    bit found;
    logic [9:0] exp_pc;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    rom[2] = 9'h044;
    rom[3] = 9'h1FF; rom[10] = 9'h1FF;
    exp_pc = zero_val ? tb_targets[4] : 10'd3;
    start_m = 1; tick(); start_m = 0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (bus_m.instr_valid_o === 1'b1 && bus_m.pc_o === 10'd2) found = 1;
      else begin
        bus_m.branch_i = !bus_m.instr_valid_o;
        bus_m.zero_i   = !bus_m.instr_valid_o;
        tick();
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL branch_reach pc2 not issued within bound, pc=%0d", bus_m.pc_o);
    end else begin
      bus_m.branch_i = 1; bus_m.zero_i = zero_val;
      tick();
      bus_m.branch_i = 0; bus_m.zero_i = 0;
      total++;
      if (bus_m.imem_en_o !== 1'b1 || bus_m.imem_addr_o !== exp_pc) begin
        bad++;
        $display("FAIL branch_fetch zero=%b en=%b addr=%0d want en=1 addr=%0d",
                 zero_val, bus_m.imem_en_o, bus_m.imem_addr_o, exp_pc);
      end
      tick();
      total++;
      if (bus_m.instr_valid_o !== 1'b1 || bus_m.pc_o !== exp_pc || bus_m.instr_o !== 9'h1FF) begin
        bad++;
        $display("FAIL branch_issue zero=%b valid=%b pc=%0d instr=%h want valid=1 pc=%0d instr=1ff",
                 zero_val, bus_m.instr_valid_o, bus_m.pc_o, bus_m.instr_o, exp_pc);
      end
      tick();
      total++;
      if (done_m !== 1'b1 || err_m !== 1'b0) begin
        bad++;
        $display("FAIL branch_done done=%b err=%b want done=1 err=0", done_m, err_m);
      end
    end
  endtask

  task automatic test_backpressure();
    bit found, seen;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    rom[0] = 9'h000; rom[1] = 9'h020; rom[2] = 9'h040; rom[3] = 9'h1FF;
    bus_m.instr_ready_i = 0;
    start_m = 1; tick(); start_m = 0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (bus_m.instr_valid_o === 1'b1) found = 1;
      else tick();
    end
    bus_m.instr_ready_i = 1; tick();
    bus_m.instr_ready_i = 0; tick();
    for (int s = 0; s < 5; s++) begin
      total++;
      if (bus_m.instr_valid_o !== 1'b1 || bus_m.pc_o !== 10'd1 || bus_m.instr_o !== 9'h020 ||
          bus_m.ctrl_instr_o !== 5'h02 || bus_m.imem_en_o !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d valid=%b pc=%0d instr=%h ctrl=%h en=%b want valid=1 pc=1 instr=020 ctrl=02 en=0",
                 s, bus_m.instr_valid_o, bus_m.pc_o, bus_m.instr_o, bus_m.ctrl_instr_o, bus_m.imem_en_o);
      end
      tick();
    end
    bus_m.instr_ready_i = 1; tick();
    total++;
    if (bus_m.instr_valid_o !== 1'b0 || bus_m.imem_en_o !== 1'b1 || bus_m.imem_addr_o !== 10'd2) begin
      bad++;
      $display("FAIL stall_release valid=%b en=%b addr=%0d want valid=0 en=1 addr=2",
               bus_m.instr_valid_o, bus_m.imem_en_o, bus_m.imem_addr_o);
    end
    tick();
    total++;
    if (bus_m.instr_valid_o !== 1'b1 || bus_m.pc_o !== 10'd2 || bus_m.instr_o !== 9'h040) begin
      bad++;
      $display("FAIL stall_next valid=%b pc=%0d instr=%h want valid=1 pc=2 instr=040",
               bus_m.instr_valid_o, bus_m.pc_o, bus_m.instr_o);
    end
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = done_m;
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    for (int i = 0; i < 1024; i++) rom[i] = 9'(i);
    bus_m.instr_ready_i = 1;
    start_m = 1; tick(); start_m = 0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (bus_m.instr_valid_o === 1'b1 && bus_m.pc_o === 10'd5) found = 1;
      else tick();
    end
    rst_n = 0;
    #1;
    total++;
    if (!found || {bus_m.imem_en_o, bus_m.imem_addr_o, bus_m.instr_o, bus_m.instr_valid_o,
                   bus_m.pc_o, done_m, err_m} !== '0) begin
      bad++;
      $display("FAIL reset_mid found=%b en=%b addr=%0d instr=%h valid=%b pc=%0d done=%b want found=1 all 0",
               found, bus_m.imem_en_o, bus_m.imem_addr_o, bus_m.instr_o, bus_m.instr_valid_o,
               bus_m.pc_o, done_m);
    end
    tick();
    rst_n = 1;
    tick();
    start_m = 1; tick(); start_m = 0;
    total++;
    if (bus_m.imem_en_o !== 1'b1 || bus_m.imem_addr_o !== 10'd0) begin
      bad++;
      $display("FAIL reset_restart en=%b addr=%0d want en=1 addr=0", bus_m.imem_en_o, bus_m.imem_addr_o);
    end
    tick();
    total++;
    if (bus_m.instr_valid_o !== 1'b1 || bus_m.pc_o !== 10'd0 || bus_m.instr_o !== 9'h000) begin
      bad++;
      $display("FAIL reset_reissue valid=%b pc=%0d instr=%h want valid=1 pc=0 instr=000",
               bus_m.instr_valid_o, bus_m.pc_o, bus_m.instr_o);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) rom_ov[i] = 9'($urandom_range(0, 9'h1FE));
    bus_o.instr_ready_i = 1; bus_o.branch_i = 0; bus_o.zero_i = 0;
    start_o = 1; tick(); start_o = 0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (bus_o.imem_en_o !== 1'b1 || bus_o.imem_addr_o !== 3'(k)) begin
        bad++;
        $display("FAIL ovf_fetch en=%b addr=%0d want en=1 addr=%0d", bus_o.imem_en_o, bus_o.imem_addr_o, k);
      end
      tick();
      total++;
      if (bus_o.instr_valid_o !== 1'b1 || bus_o.pc_o !== 3'(k) || bus_o.instr_o !== rom_ov[k]) begin
        bad++;
        $display("FAIL ovf_issue valid=%b pc=%0d instr=%h want valid=1 pc=%0d instr=%h",
                 bus_o.instr_valid_o, bus_o.pc_o, bus_o.instr_o, k, rom_ov[k]);
      end
      tick();
    end
    for (int s = 0; s < 4; s++) begin
      total++;
      if (done_o_ov !== 1'b1 || err_o_ov !== 1'b1 || bus_o.imem_addr_o === 3'd0 || bus_o.imem_en_o !== 1'b0) begin
        bad++;
        $display("FAIL ovf_done done=%b err=%b addr=%0d en=%b want done=1 err=1 addr!=0 en=0",
                 done_o_ov, err_o_ov, bus_o.imem_addr_o, bus_o.imem_en_o);
      end
      tick();
    end
    start_o = 1; tick(); start_o = 0;
    total++;
    if (done_o_ov !== 1'b0 || err_o_ov !== 1'b0 || bus_o.imem_en_o !== 1'b1 || bus_o.imem_addr_o !== 3'd0) begin
      bad++;
      $display("FAIL ovf_restart done=%b err=%b en=%b addr=%0d want done=0 err=0 en=1 addr=0",
               done_o_ov, err_o_ov, bus_o.imem_en_o, bus_o.imem_addr_o);
    end
  endtask

  // Interpreter: each accepted word moves the expected PC by the fetch rules
  task automatic test_random(input int iters);
    logic [9:0] exp_pc;
    bit exp_done, exp_err, fetch_due, finished, rdy, b, z;
    int n_acc;
    for (int it = 0; it < iters; it++) begin
      rst_n = 0; tick(); rst_n = 1; tick();
      for (int i = 0; i < 1024; i++)
        rom[i] = ($urandom_range(0, 15) == 0) ? 9'h1FF : 9'($urandom_range(0, 9'h1FE));
      exp_pc = 0; exp_done = 0; exp_err = 0; n_acc = 0; finished = 0; fetch_due = 1;
      start_m = 1; tick(); start_m = 0;
      for (int c = 0; c < 400 && !finished; c++) begin
        if (exp_done) begin
          total++;
          if (done_m !== 1'b1 || err_m !== exp_err || bus_m.instr_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL rnd_done it=%0d done=%b err=%b valid=%b want done=1 err=%b valid=0",
                     it, done_m, err_m, bus_m.instr_valid_o, exp_err);
          end
          finished = 1;
        end else if (fetch_due) begin
          total++;
          if (bus_m.imem_en_o !== 1'b1 || bus_m.imem_addr_o !== exp_pc || bus_m.instr_valid_o !== 1'b0 || done_m !== 1'b0) begin
            bad++;
            $display("FAIL rnd_fetch it=%0d en=%b addr=%0d valid=%b done=%b want en=1 addr=%0d",
                     it, bus_m.imem_en_o, bus_m.imem_addr_o, bus_m.instr_valid_o, done_m, exp_pc);
          end
          fetch_due = 0;
          bus_m.branch_i = 1'($urandom_range(0, 1));
          bus_m.zero_i   = 1'($urandom_range(0, 1));
          tick();
        end else begin
          total++;
          if (bus_m.instr_valid_o !== 1'b1 || bus_m.pc_o !== exp_pc || bus_m.instr_o !== rom[exp_pc] ||
              bus_m.imem_en_o !== 1'b0) begin
            bad++;
            $display("FAIL rnd_issue it=%0d valid=%b pc=%0d instr=%h en=%b want valid=1 pc=%0d instr=%h",
                     it, bus_m.instr_valid_o, bus_m.pc_o, bus_m.instr_o, bus_m.imem_en_o, exp_pc, rom[exp_pc]);
          end
          rdy = ($urandom_range(0, 3) != 0);
          b   = 1'($urandom_range(0, 1));
          z   = 1'($urandom_range(0, 1));
          bus_m.instr_ready_i = rdy; bus_m.branch_i = b; bus_m.zero_i = z;
          if (rdy) begin
            n_acc++;
            if (rom[exp_pc] == 9'h1FF) begin
              exp_done = 1; exp_err = 0;
            end else if (b && z) begin
              exp_pc = tb_targets[rom[exp_pc][3:0]];
            end else if (exp_pc == 10'd1023) begin
              exp_done = 1; exp_err = 1;
            end else begin
              exp_pc = exp_pc + 10'd1;
            end
            if (!exp_done) fetch_due = 1;
          end
          tick();
          if (n_acc >= 40 && !exp_done) finished = 1;
        end
      end
      total++;
      if (!finished) begin
        bad++;
        $display("FAIL rnd_timeout it=%0d accepts=%0d cycle budget expired", it, n_acc);
      end
    end
    bus_m.instr_ready_i = 1; bus_m.branch_i = 0; bus_m.zero_i = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    tb_targets = '{10'd0, 10'd16, 10'd32, 10'd48, 10'd10, 10'd64, 10'd80, 10'd96,
                   10'd128, 10'd160, 10'd200, 10'd256, 10'd300, 10'd400, 10'd512, 10'd1000};
    test_reset();
    test_straight();
    test_restart();
    test_branch(1'b1);
    test_branch(1'b0);
    test_backpressure();
    test_reset_mid();
    test_overflow();
    test_random(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
